// File: rtl/rrpe_pkg.sv
// Shared constants and helpers for the round-robin priority encoder.
// Optional request masking is enabled by defining RRPE_MASK_EN.
package rrpe_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    // Index width for an n-entry request vector, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Next index after idx, wrapping at n rather than at a power of two.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rrpe_pick.sv
// Combinational picker: selects one index from a request vector.
// Fixed mode picks the highest set bit. Round-robin mode picks the first
// set bit found when scanning upward from start_i with wrap modulo N.
// The round-robin search doubles the vector, rotates it so that start_i
// lands at bit 0, and scans upward from there.
module rrpe_pick
    import rrpe_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = idx_w(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] start_i,
    input  logic         mode_i,
    output logic         found_o,
    output logic [W-1:0] idx_o,
    output logic         multi_o
);

    localparam int WP = W + 1;

    logic [2*N-1:0] dblReq;
    logic [N-1:0]   rotReq;
    logic [W-1:0]   rotOffset;
    logic [W-1:0]   fixIdx;
    logic [WP-1:0]  rrSum;

    assign dblReq = {req_i, req_i};

    // Rotate the doubled vector so that rotReq[0] is the request at start_i.
    always_comb begin
        rotReq = '0;
        for (int k = 0; k < N; k++) begin
            rotReq[k] = dblReq[{1'b0, start_i} + WP'(k)];
        end
    end

    // Find the lowest set bit of the rotated vector, which is the distance from start_i.
    always_comb begin
        rotOffset = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rotReq[k]) begin
                rotOffset = W'(k);
            end
        end
    end

    // Find the highest set bit of the unrotated vector for fixed priority.
    always_comb begin
        fixIdx = '0;
        for (int k = 0; k < N; k++) begin
            if (req_i[k]) begin
                fixIdx = W'(k);
            end
        end
    end

    // Map the rotated offset back to an absolute index, wrapping modulo N.
    always_comb begin
        rrSum = {1'b0, start_i} + {1'b0, rotOffset};
        if (rrSum >= WP'(N)) begin
            rrSum = rrSum - WP'(N);
        end
    end

    assign found_o = |req_i;
    assign multi_o = |(req_i & (req_i - N'(1)));
    assign idx_o   = mode_i ? rrSum[W-1:0] : fixIdx;

endmodule

// File: rtl/rr_priority_encoder.sv
// Registered N-input priority encoder with a valid/ready output handshake.
// MODE selects fixed priority (highest index wins) or round-robin.
// When RRPE_MASK_EN is defined, the port req_mask_i is added and masked
// requests are removed before picking.
module rr_priority_encoder
    import rrpe_pkg::*;
#(
    parameter  int N    = 8,
    parameter  int MODE = 1,
    localparam int W    = idx_w(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_i,
`ifdef RRPE_MASK_EN
    input  logic [N-1:0] req_mask_i,
`endif
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_idx,
    output logic         out_multi
);

    localparam logic IS_RR = (MODE == MODE_RR);

    logic         valid_q, valid_d;
    logic [W-1:0] idx_q, idx_d;
    logic         multi_q, multi_d;
    logic [W-1:0] ptr_q, ptr_d;

    logic [N-1:0] reqEff;
    logic         loadEn;
    logic [W-1:0] startIdx;
    logic         pickFound;
    logic [W-1:0] pickIdx;
    logic         pickMulti;

`ifdef RRPE_MASK_EN
    assign reqEff = req_i & ~req_mask_i;
`else
    assign reqEff = req_i;
`endif

    assign loadEn   = !valid_q || out_ready;
    assign startIdx = W'(wrap_inc(int'(ptr_q), N));

    rrpe_pick #(
        .N(N)
    ) u_pick (
        .req_i   (reqEff),
        .start_i (startIdx),
        .mode_i  (IS_RR),
        .found_o (pickFound),
        .idx_o   (pickIdx),
        .multi_o (pickMulti)
    );

    // Load a new grant when the output slot is free or being consumed; otherwise hold.
    always_comb begin
        valid_d = valid_q;
        idx_d   = idx_q;
        multi_d = multi_q;
        ptr_d   = ptr_q;
        if (loadEn) begin
            if (pickFound) begin
                valid_d = 1'b1;
                idx_d   = pickIdx;
                multi_d = pickMulti;
                if (IS_RR) begin
                    ptr_d = pickIdx;
                end
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    // Output register and round-robin pointer; reset discards any pending grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            idx_q   <= '0;
            multi_q <= 1'b0;
            ptr_q   <= W'(N - 1);
        end else begin
            valid_q <= valid_d;
            idx_q   <= idx_d;
            multi_q <= multi_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_valid = valid_q;
    assign out_idx   = idx_q;
    assign out_multi = multi_q;

endmodule

// File: tb/tb_rr_priority_encoder.sv
// Testbench for rr_priority_encoder: three instances (N=8 round-robin,
// N=8 fixed, N=5 round-robin) checked every cycle against a behavioural
// model, plus directed literal expectations.
module tb_rr_priority_encoder;

    logic clk;
    logic rst;
    logic started;

    logic [7:0] reqArr  [3];
    logic [7:0] maskArr [3];
    logic       rdyArr  [3];

    logic       dutValid [3];
    logic [7:0] dutIdx   [3];
    logic       dutMulti [3];

    logic [2:0] idx0, idx1, idx2;
    logic       val0, val1, val2;
    logic       mul0, mul1, mul2;

    int nArr    [3] = '{8, 8, 5};
    int modeArr [3] = '{1, 0, 1};

    logic       mValid [3];
    int         mIdx   [3];
    logic       mMulti [3];
    int         mPtr   [3];
    logic [7:0] effNow [3];
    int         pickNow[3];

    int checkCount;
    int errCount;

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    rr_priority_encoder #(.N(8), .MODE(1)) dutRr8 (
        .clk       (clk),
        .rst       (rst),
        .req_i     (reqArr[0]),
`ifdef RRPE_MASK_EN
        .req_mask_i(maskArr[0]),
`endif
        .out_ready (rdyArr[0]),
        .out_valid (val0),
        .out_idx   (idx0),
        .out_multi (mul0)
    );

    rr_priority_encoder #(.N(8), .MODE(0)) dutFx8 (
        .clk       (clk),
        .rst       (rst),
        .req_i     (reqArr[1]),
`ifdef RRPE_MASK_EN
        .req_mask_i(maskArr[1]),
`endif
        .out_ready (rdyArr[1]),
        .out_valid (val1),
        .out_idx   (idx1),
        .out_multi (mul1)
    );

    rr_priority_encoder #(.N(5), .MODE(1)) dutRr5 (
        .clk       (clk),
        .rst       (rst),
        .req_i     (reqArr[2][4:0]),
`ifdef RRPE_MASK_EN
        .req_mask_i(maskArr[2][4:0]),
`endif
        .out_ready (rdyArr[2]),
        .out_valid (val2),
        .out_idx   (idx2),
        .out_multi (mul2)
    );

    assign dutValid[0] = val0;
    assign dutValid[1] = val1;
    assign dutValid[2] = val2;
    assign dutIdx[0]   = {5'd0, idx0};
    assign dutIdx[1]   = {5'd0, idx1};
    assign dutIdx[2]   = {5'd0, idx2};
    assign dutMulti[0] = mul0;
    assign dutMulti[1] = mul1;
    assign dutMulti[2] = mul2;

    // Model pick: fixed takes the highest set index, round-robin walks ptr+1, ptr+2, ... mod n.
    function automatic int modelPick(input logic [7:0] eff, input int n, input int mode, input int ptr);
        int pick;
        int cand;
        pick = -1;
        if (mode == 0) begin
            for (int i = 0; i < n; i++) begin
                if (eff[i]) pick = i;
            end
        end else begin
            for (int s = n; s >= 1; s--) begin
                cand = (ptr + s) % n;
                if (eff[cand]) pick = cand;
            end
        end
        return pick;
    endfunction

    // Effective requests and the model's choice for the current inputs.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            effNow[i]  = reqArr[i] & ~maskArr[i] & 8'((1 << nArr[i]) - 1);
            pickNow[i] = modelPick(effNow[i], nArr[i], modeArr[i], mPtr[i]);
        end
    end

    // Behavioural model state advances on each rising edge.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                mValid[i] <= 1'b0;
                mIdx[i]   <= 0;
                mMulti[i] <= 1'b0;
                mPtr[i]   <= nArr[i] - 1;
            end else if (!mValid[i] || rdyArr[i]) begin
                if (pickNow[i] >= 0) begin
                    mValid[i] <= 1'b1;
                    mIdx[i]   <= pickNow[i];
                    mMulti[i] <= ($countones(effNow[i]) > 1);
                    if (modeArr[i] == 1) mPtr[i] <= pickNow[i];
                end else begin
                    mValid[i] <= 1'b0;
                end
            end
        end
    end

    // Compare every instance against the model on each falling edge.
    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 3; i++) begin
                checkCount++;
                if (dutValid[i] !== mValid[i]) begin
                    errCount++;
                    $display("[TB] FAIL model_valid inst%0d got %0b want %0b", i, dutValid[i], mValid[i]);
                end
                checkCount++;
                if (dutIdx[i] !== 8'(mIdx[i])) begin
                    errCount++;
                    $display("[TB] FAIL model_idx inst%0d got %0d want %0d", i, dutIdx[i], mIdx[i]);
                end
                checkCount++;
                if (dutMulti[i] !== mMulti[i]) begin
                    errCount++;
                    $display("[TB] FAIL model_multi inst%0d got %0b want %0b", i, dutMulti[i], mMulti[i]);
                end
                checkCount++;
                if (dutIdx[i] >= 8'(nArr[i])) begin
                    errCount++;
                    $display("[TB] FAIL idx_range inst%0d got %0d limit %0d", i, dutIdx[i], nArr[i] - 1);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int inst, input logic [7:0] req, input logic rdy);
        reqArr[inst] = req;
        rdyArr[inst] = rdy;
    endtask

    task automatic checkOutput(input int inst, input logic expV, input int expI, input logic expM, input string name);
        checkCount++;
        if (dutValid[inst] !== expV || dutIdx[inst] !== 8'(expI) || dutMulti[inst] !== expM) begin
            errCount++;
            $display("[TB] FAIL %s inst%0d got v=%0b i=%0d m=%0b want v=%0b i=%0d m=%0b",
                     name, inst, dutValid[inst], dutIdx[inst], dutMulti[inst], expV, expI, expM);
        end
    endtask

    // Directed stimulus with hand-computed expectations.
    initial begin
        checkCount = 0;
        errCount   = 0;
        started    = 1'b0;
        rst        = 1'b1;
        for (int i = 0; i < 3; i++) begin
            reqArr[i]  = 8'h00;
            maskArr[i] = 8'h00;
            rdyArr[i]  = 1'b1;
        end
        reqArr[0] = 8'hFF;

        // Reset held for two edges with all requests active.
        tick();
        started = 1'b1;
        checkOutput(0, 1'b0, 0, 1'b0, "rst_edge1");
        tick();
        checkOutput(0, 1'b0, 0, 1'b0, "rst_edge2");
        rst = 1'b0;

        // Round-robin over all-ones: 0 first, then 1..7 and wrapping.
        tick();
        checkOutput(0, 1'b1, 0, 1'b1, "rr_first");
        for (int k = 1; k <= 15; k++) begin
            tick();
            checkOutput(0, 1'b1, k % 8, 1'b1, "rr_rotate");
        end

        // Grant 0 then hold it through a request drop while not ready.
        applyStimulus(0, 8'h81, 1'b1);
        tick();
        checkOutput(0, 1'b1, 0, 1'b1, "rr_load0");
        applyStimulus(0, 8'h81, 1'b0);
        tick();
        checkOutput(0, 1'b1, 0, 1'b1, "hold1");
        applyStimulus(0, 8'h80, 1'b0);
        tick();
        checkOutput(0, 1'b1, 0, 1'b1, "hold2");
        tick();
        checkOutput(0, 1'b1, 0, 1'b1, "hold3");
        applyStimulus(0, 8'h80, 1'b1);
        tick();
        checkOutput(0, 1'b1, 7, 1'b0, "after_hold");
        tick();
        checkOutput(0, 1'b1, 7, 1'b0, "lone_regrant");

        // Reset while a grant is pending discards it and restores the pointer.
        applyStimulus(0, 8'hFF, 1'b0);
        tick();
        checkOutput(0, 1'b1, 7, 1'b0, "pending");
        rst = 1'b1;
        tick();
        checkOutput(0, 1'b0, 0, 1'b0, "rst_discard");
        rst = 1'b0;
        applyStimulus(0, 8'h00, 1'b1);
        tick();
        checkOutput(0, 1'b0, 0, 1'b0, "no_represent");
        applyStimulus(0, 8'hFF, 1'b1);
        tick();
        checkOutput(0, 1'b1, 0, 1'b1, "ptr_restart");

        // Fixed priority: highest set index wins every cycle.
        applyStimulus(1, 8'h2C, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput(1, 1'b1, 5, 1'b1, "fx_pick5");
        end
        applyStimulus(1, 8'h00, 1'b1);
        tick();
        checkOutput(1, 1'b0, 5, 1'b1, "fx_idle");
        applyStimulus(1, 8'h01, 1'b1);
        tick();
        checkOutput(1, 1'b1, 0, 1'b0, "fx_single");

        // N=5 round-robin: wrap modulo 5 and re-grant of a lone pointer index.
        applyStimulus(2, 8'h08, 1'b1);
        tick();
        checkOutput(2, 1'b1, 3, 1'b0, "n5_grant3");
        applyStimulus(2, 8'h0A, 1'b1);
        tick();
        checkOutput(2, 1'b1, 1, 1'b1, "n5_wrap1");
        tick();
        checkOutput(2, 1'b1, 3, 1'b1, "n5_next3");
        tick();
        checkOutput(2, 1'b1, 1, 1'b1, "n5_again1");
        applyStimulus(2, 8'h10, 1'b1);
        tick();
        checkOutput(2, 1'b1, 4, 1'b0, "n5_grant4");
        tick();
        checkOutput(2, 1'b1, 4, 1'b0, "n5_regrant4");

`ifdef RRPE_MASK_EN
        // Masked requests are excluded from both picking and the multi flag.
        applyStimulus(1, 8'hC0, 1'b1);
        maskArr[1] = 8'h80;
        tick();
        checkOutput(1, 1'b1, 6, 1'b0, "mask_pick6");
        maskArr[1] = 8'hC0;
        tick();
        checkOutput(1, 1'b0, 6, 1'b0, "mask_all");
`endif

        tick();
        $display("CHECKS %0d ERRORS %0d", checkCount, errCount);
        $finish;
    end

endmodule
